// File: rtl/aes_sub_shift.sv
// Iterative AES SubBytes + ShiftRows stage, ROWS_PER_CYCLE state rows per clock.
// Holds one block at a time with valid/ready handshakes on both sides.
module aes_sub_shift #(
  parameter int unsigned ROWS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  if (ROWS_PER_CYCLE != 1 && ROWS_PER_CYCLE != 2 && ROWS_PER_CYCLE != 4) begin : g_bad_rows
    $error("aes_sub_shift: ROWS_PER_CYCLE must be 1, 2 or 4");
  end

  // FIPS-197 forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [1:0] ROW_STEP = 2'(ROWS_PER_CYCLE);
  localparam logic [1:0] ROW_SPAN = 2'(ROWS_PER_CYCLE - 1);

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state;
  logic [127:0] src_reg;
  logic [127:0] res_reg;
  logic [1:0]   row_cnt;
  logic [127:0] res_next;
  logic [1:0]   row_r;
  logic [1:0]   src_c;
  logic [3:0]   src_idx;
  logic [3:0]   dst_idx;
  logic         last_step;

  assign data_out  = res_reg;
  assign last_step = (row_cnt + ROW_SPAN) == 2'd3;

  // Byte (r,c) sits at bit offset 8*(15-(4r+c)), i.e. {~r,~c,3'b000}.
  always_comb begin
    res_next = res_reg;
    row_r    = '0;
    src_c    = '0;
    src_idx  = '0;
    dst_idx  = '0;
    for (int unsigned k = 0; k < ROWS_PER_CYCLE; k++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        row_r   = row_cnt + 2'(k);
        src_c   = row_r + 2'(c);
        src_idx = ~{row_r, src_c};
        dst_idx = ~{row_r, 2'(c)};
        res_next[{dst_idx, 3'b000} +: 8] = sbox(src_reg[{src_idx, 3'b000} +: 8]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row_cnt   <= '0;
      src_reg   <= '0;
      res_reg   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            src_reg  <= data_in;
            row_cnt  <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          res_reg <= res_next;
          row_cnt <= row_cnt + ROW_STEP;
          if (last_step) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sub_shift.sv
// Bench for aes_sub_shift: three instances (1, 2 and 4 rows per cycle), a
// GF(2^8)-derived reference model checked every cycle, plus directed vectors.
module tb_aes_sub_shift;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic [127:0] data_in  [3];
  logic [127:0] data_out [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_sub_shift #(.ROWS_PER_CYCLE(1 << g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .data_in  (data_in[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .data_out (data_out[g])
    );
  end

  localparam logic [127:0] FIPS_IN  = 128'h19a09ae9_3df4c6f8_e3e28d48_be2b2a08;
  localparam logic [127:0] FIPS_OUT = 128'hd4e0b81e_bfb44127_5d521198_30aef1e5;
  localparam logic [127:0] ROT_IN   = 128'h00010203_10111213_20212223_30313233;
  localparam logic [127:0] ROT_OUT  = 128'h637c777b_82c97dca_9326b7fd_c304c723;
  localparam logic [127:0] ZERO_OUT = {16{8'h63}};

  // ---------------- reference model ----------------
  logic [7:0] sbox_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] t;
    t = b;
    for (int i = 0; i < n; i++) t = {t[6:0], t[7]};
    return t;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, v;
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      inv = '0;
      for (int x = 1; x < 256; x++)
        if (gmul(v, 8'(x)) == 8'h01) inv = 8'(x);
      sbox_m[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] blk);
    logic [7:0]   st [4][4];
    logic [127:0] res;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        st[r][c] = blk[127 - 8*(4*r + c) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[127 - 8*(4*r + c) -: 8] = sbox_m[st[r][(c + r) % 4]];
    return res;
  endfunction

  bit           m_known = 1'b0;
  bit           m_idle [3];
  int           m_wait [3];
  bit           m_zero [3];
  logic [127:0] m_res  [3];

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_idle[d] = 1'b1; m_wait[d] = 0; m_zero[d] = 1'b1;
      end else if (m_idle[d]) begin
        if (in_valid[d]) begin
          m_idle[d] = 1'b0;
          m_wait[d] = 4 / (1 << d);
          m_res[d]  = aes_ref(data_in[d]);
          m_zero[d] = 1'b0;
        end
      end else if (m_wait[d] > 0) begin
        m_wait[d]--;
      end else if (out_ready[d]) begin
        m_idle[d] = 1'b1;
      end
    end
    if (rst) m_known = 1'b1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_known) begin
      for (int d = 0; d < 3; d++) begin
        bit exp_valid;
        exp_valid = !m_idle[d] && m_wait[d] == 0;
        chk($sformatf("model_in_ready[%0d]", d), 128'(in_ready[d]), 128'(m_idle[d]));
        chk($sformatf("model_out_valid[%0d]", d), 128'(out_valid[d]), 128'(exp_valid));
        if (exp_valid || m_zero[d])
          chk($sformatf("model_data_out[%0d]", d), data_out[d], m_zero[d] ? '0 : m_res[d]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic accept(input int d, input logic [127:0] blk);
    int n;
    data_in[d]  = blk;
    in_valid[d] = 1'b1;
    n = 0;
    while (!in_ready[d] && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk($sformatf("accept_ready[%0d]", d), 128'(in_ready[d]), 128'(1));
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    data_in[d]  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic expect_result(input int d, input logic [127:0] exp, input int exp_lat,
                               input bit scramble);
    int lat;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid[d]) break;
      lat++;
      if (scramble) begin
        #1 data_in[d] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    chk($sformatf("latency[%0d]", d), 128'(lat), 128'(exp_lat));
    chk($sformatf("data_out[%0d]", d), data_out[d], exp);
    #1 out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    @(negedge clk);
    chk($sformatf("valid_drop[%0d]", d), 128'(out_valid[d]), 128'(0));
    chk($sformatf("ready_back[%0d]", d), 128'(in_ready[d]), 128'(1));
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    rst = 1'b1;
    in_valid = '0;
    out_ready = '0;
    for (int d = 0; d < 3; d++) data_in[d] = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_in_ready[%0d]", d), 128'(in_ready[d]), 128'(1));
      chk($sformatf("reset_out_valid[%0d]", d), 128'(out_valid[d]), 128'(0));
      chk($sformatf("reset_data_out[%0d]", d), data_out[d], '0);
    end
    #1 rst = 1'b0;

    // Pin the model itself against hand-derived values.
    chk("model_s00", 128'(sbox_m[8'h00]), 128'h63);
    chk("model_s53", 128'(sbox_m[8'h53]), 128'hed);
    chk("model_fips", aes_ref(FIPS_IN), FIPS_OUT);
    chk("model_rot", aes_ref(ROT_IN), ROT_OUT);
    chk("model_zero", aes_ref('0), ZERO_OUT);

    // FIPS-197 round 1 vector
    accept(0, FIPS_IN);
    expect_result(0, FIPS_OUT, 4, 1'b0);

    // All-zero block at each width
    for (int d = 0; d < 3; d++) begin
      accept(d, '0);
      expect_result(d, ZERO_OUT, 4 / (1 << d), 1'b0);
    end

    // Rotation check at each width
    for (int d = 0; d < 3; d++) begin
      accept(d, ROT_IN);
      expect_result(d, ROT_OUT, 4 / (1 << d), 1'b0);
    end

    // Backpressure with a second block waiting upstream
    accept(0, FIPS_IN);
    for (int i = 0; i < 20 && !out_valid[0]; i++) @(negedge clk);
    #1;
    in_valid[0] = 1'b1;
    data_in[0]  = ROT_IN;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_data_stable", data_out[0], FIPS_OUT);
      chk("bp_in_ready", 128'(in_ready[0]), 128'(0));
      chk("bp_out_valid", 128'(out_valid[0]), 128'(1));
    end
    #1 out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    @(negedge clk);
    chk("bp_release_ready", 128'(in_ready[0]), 128'(1));
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    data_in[0]  = '0;
    expect_result(0, ROT_OUT, 4, 1'b0);

    // Reset on the second BUSY edge
    accept(0, ROT_IN);
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready", 128'(in_ready[0]), 128'(1));
    chk("rst_mid_out_valid", 128'(out_valid[0]), 128'(0));
    chk("rst_mid_data_out", data_out[0], '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_no_valid", 128'(out_valid[0]), 128'(0));
    end
    #1;
    accept(0, FIPS_IN);
    expect_result(0, FIPS_OUT, 4, 1'b0);

    // data_in changes every cycle while busy
    accept(0, FIPS_IN);
    expect_result(0, FIPS_OUT, 4, 1'b1);
    accept(1, ROT_IN);
    expect_result(1, ROT_OUT, 2, 1'b1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
